uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_core_if.sv | 21 ++
 rtl/uart_tx_core.sv | 103 ++++++++++
 tb/tb_uart_tx_core.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_core_if.sv
// Parallel-load request and serial-line status bundle for the UART transmitter.
interface uart_tx_core_if #(
  parameter int P_DATA_WIDTH = 8
);
  logic [P_DATA_WIDTH-1:0] p_data;
  logic                    data_valid;
  logic                    par_en;
  logic                    par_typ;
  logic                    s_data;
  logic                    busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  s_data, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output s_data, busy
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART frame serializer: start bit, LSB-first data, optional parity, stop bit.
// state  | meaning
// IDLE   | line high, waiting for data_valid
// START  | start bit (0)
// DATA   | data bits, bit_cnt selects the bit
// PARITY | parity bit (even or odd per latched par_typ)
// STOP   | stop bit (1); data_valid here chains straight into START
module uart_tx_core #(
  parameter int P_DATA_WIDTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  uart_tx_core_if.slave tx
);

  localparam int CW = (P_DATA_WIDTH > 1) ? $clog2(P_DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(P_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [P_DATA_WIDTH-1:0] data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    s_data_q, s_data_d;
  logic                    busy_q, busy_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      cnt_q     <= '0;
      s_data_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      cnt_q     <= cnt_d;
      s_data_q  <= s_data_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE, S_STOP: begin
        if (tx.data_valid) begin
          data_d    = tx.p_data;
          par_en_d  = tx.par_en;
          par_typ_d = tx.par_typ;
          state_d   = S_START;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_PARITY: state_d = S_STOP;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are computed from next state and registered, so the line never glitches.
    s_data_d = 1'b1;
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_START:  s_data_d = 1'b0;
      S_DATA:   s_data_d = data_d[cnt_d];
      S_PARITY: s_data_d = (^data_d) ^ par_typ_d;
      default:  s_data_d = 1'b1;
    endcase
  end

  assign tx.s_data = s_data_q;
  assign tx.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Table-driven and scoreboard-checked bench for uart_tx_core.
module tb_uart_tx_core;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_core_if #(.P_DATA_WIDTH(W)) tx_if ();

  uart_tx_core #(.P_DATA_WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .tx    (tx_if)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         pe;
    logic         pt;
    logic         par;
    int           len;
  } vec_t;

  logic [1:0] sb[$];
  int n_vec = 0;
  int n_err = 0;
  int sb_idx = 0;

  // Scoreboard: one expected {s_data, busy} pair per negedge while entries remain.
  initial begin
    logic [1:0] exp_v;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        n_vec++;
        if ({tx_if.s_data, tx_if.busy} !== exp_v) begin
          n_err++;
          $display("FAIL line_sample[%0d] t=%0t: {s_data,busy} got %b%b expected %b%b",
                   sb_idx, $time, tx_if.s_data, tx_if.busy, exp_v[1], exp_v[0]);
        end
        sb_idx++;
      end
    end
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: {s_data,busy} got %b expected %b", name, act, exp_v);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d, input int len, input logic par);
    sb.push_back(2'b01);
    for (int i = 0; i < W; i++) sb.push_back({d[i], 1'b1});
    if (len == W + 3) sb.push_back({par, 1'b1});
    sb.push_back(2'b11);
  endtask

  task automatic drive_req(input logic [W-1:0] d, input logic pe, input logic pt);
    tx_if.p_data     = d;
    tx_if.par_en     = pe;
    tx_if.par_typ    = pt;
    tx_if.data_valid = 1'b1;
  endtask

  // Frame is accepted at the next edge; inputs are scrambled afterwards to prove latching.
  task automatic accept_frame(input logic [W-1:0] d, input int len, input logic par);
    @(posedge clk); #1;
    push_frame(d, len, par);
    tx_if.data_valid = 1'b0;
    tx_if.p_data     = ~d;
    tx_if.par_en     = ~tx_if.par_en;
    tx_if.par_typ    = ~tx_if.par_typ;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 100 && sb.size() > 0; k++) @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL %s: scoreboard still holds %0d entries, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic expect_idle(input int n, input string name);
    for (int i = 0; i < n; i++) sb.push_back(2'b10);
    wait_drain(name);
  endtask

  vec_t tbl[8];

  initial begin
    logic [W-1:0] rd;
    logic rpe, rpt;

    tbl[0] = '{8'h5A, 1'b0, 1'b0, 1'b0, 10};
    tbl[1] = '{8'h6B, 1'b0, 1'b0, 1'b0, 10};
    tbl[2] = '{8'h5A, 1'b1, 1'b1, 1'b1, 11};
    tbl[3] = '{8'h6B, 1'b1, 1'b1, 1'b0, 11};
    tbl[4] = '{8'h5A, 1'b1, 1'b0, 1'b0, 11};
    tbl[5] = '{8'h6B, 1'b1, 1'b0, 1'b1, 11};
    tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 11};
    tbl[7] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11};

    tx_if.p_data     = '0;
    tx_if.data_valid = 1'b0;
    tx_if.par_en     = 1'b0;
    tx_if.par_typ    = 1'b0;

    repeat (2) @(posedge clk);
    #1 chk("reset_state", {tx_if.s_data, tx_if.busy}, 2'b10);
    @(posedge clk); #1 rst = 1'b0;
    expect_idle(2, "idle_after_reset");

    for (int v = 0; v < 8; v++) begin
      drive_req(tbl[v].data, tbl[v].pe, tbl[v].pt);
      accept_frame(tbl[v].data, tbl[v].len, tbl[v].par);
      wait_drain("table_frame");
      expect_idle(2, "table_idle");
    end

    // Mid-frame request with different data must be ignored.
    drive_req(8'h5A, 1'b1, 1'b0);
    accept_frame(8'h5A, 11, 1'b0);
    repeat (3) @(posedge clk); #1;
    drive_req(8'hC3, 1'b0, 1'b1);
    @(posedge clk); #1 tx_if.data_valid = 1'b0;
    wait_drain("ignore_midframe");
    expect_idle(1, "ignore_idle");

    // Data_valid high during STOP chains the next frame with no idle gap.
    drive_req(8'h6B, 1'b0, 1'b0);
    accept_frame(8'h6B, 10, 1'b0);
    repeat (9) @(posedge clk); #1;
    drive_req(8'h5A, 1'b1, 1'b1);
    accept_frame(8'h5A, 11, 1'b1);
    wait_drain("back_to_back");
    expect_idle(2, "b2b_idle");

    // Reset during data bit 3 aborts the frame immediately.
    drive_req(8'hA5, 1'b0, 1'b0);
    @(posedge clk); #1;
    tx_if.data_valid = 1'b0;
    sb.push_back(2'b01);
    sb.push_back(2'b11);
    sb.push_back(2'b01);
    sb.push_back(2'b11);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_mid_data", {tx_if.s_data, tx_if.busy}, 2'b10);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_idle(4, "no_resume_after_reset");

    // Request presented right at reset release is taken at the first edge.
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("reset_again", {tx_if.s_data, tx_if.busy}, 2'b10);
    @(posedge clk); #1 rst = 1'b0;
    drive_req(8'h3C, 1'b1, 1'b0);
    accept_frame(8'h3C, 11, 1'b0);
    wait_drain("first_edge_after_reset");
    expect_idle(1, "post_reset_idle");

    for (int r = 0; r < 6; r++) begin
      rd  = W'($urandom_range(0, 255));
      rpe = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      drive_req(rd, rpe, rpt);
      accept_frame(rd, rpe ? W + 3 : W + 2, (^rd) ^ rpt);
      wait_drain("random_frame");
      expect_idle(1, "random_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
